// File: rtl/rect_fill_engine_pkg.sv
// rect_fill_engine_pkg: screen geometry, field widths and FSM state encoding shared by the fill engine
package rect_fill_engine_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COLOR_W = 12;
  localparam int ADDR_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, FILL = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/rect_fill_engine_addr_gen.sv
// rect_fill_engine_addr_gen: row-major cx/cy/row_base counters producing the pixel address and a last-pixel flag
module rect_fill_engine_addr_gen
  import rect_fill_engine_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              adv,
  input  logic [X_W-1:0]    x0,
  input  logic [Y_W-1:0]    y0,
  input  logic [X_W:0]      x_end,
  input  logic [Y_W:0]      y_end,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic [ADDR_W-1:0] row_base;
  logic row_end;
  always_comb begin
    row_end = {1'b0, cx} == x_end - (X_W+1)'(1);
    last = row_end && ({1'b0, cy} == y_end - (Y_W+1)'(1));
    addr = row_base + ADDR_W'(cx);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cx <= '0;
      cy <= '0;
      row_base <= '0;
    end else if (load) begin
      cx <= x0;
      cy <= y0;
      row_base <= ADDR_W'(y0) * ADDR_W'(SCREEN_W);
    end else if (adv) begin
      cx <= row_end ? x0 : cx + X_W'(1);
      cy <= row_end ? cy + Y_W'(1) : cy;
      row_base <= row_end ? row_base + ADDR_W'(SCREEN_W) : row_base;
    end
  end
endmodule

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: clipped rectangle fill issuing one VRAM pixel write per accepted cycle
module rect_fill_engine
  import rect_fill_engine_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [X_W-1:0]     cmd_x,
  input  logic [Y_W-1:0]     cmd_y,
  input  logic [X_W-1:0]     cmd_w,
  input  logic [Y_W-1:0]     cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               busy,
  output logic               done,
  output logic               vram_we,
  input  logic               vram_ready,
  output logic [ADDR_W-1:0]  vram_addr,
  output logic [COLOR_W-1:0] vram_data
);
  state_t state;
  logic [X_W-1:0] x_q, w_q;
  logic [Y_W-1:0] y_q, h_q;
  logic [COLOR_W-1:0] color_q;
  logic [X_W:0] x_sum, x_end_c, x_end;
  logic [Y_W:0] y_sum, y_end_c, y_end;
  logic empty, last;
  always_comb begin
    x_sum = {1'b0, x_q} + {1'b0, w_q};
    y_sum = {1'b0, y_q} + {1'b0, h_q};
    x_end_c = x_sum > (X_W+1)'(SCREEN_W) ? (X_W+1)'(SCREEN_W) : x_sum;
    y_end_c = y_sum > (Y_W+1)'(SCREEN_H) ? (Y_W+1)'(SCREEN_H) : y_sum;
    empty = ({1'b0, x_q} >= x_end_c) || ({1'b0, y_q} >= y_end_c);
  end
  assign vram_data = color_q;
  rect_fill_engine_addr_gen u_addr_gen (
    .clk(clk), .reset(reset), .load(state == SETUP), .adv(vram_we && vram_ready),
    .x0(x_q), .y0(y_q), .x_end(x_end), .y_end(y_end), .addr(vram_addr), .last(last)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      vram_we <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      w_q <= '0;
      h_q <= '0;
      color_q <= '0;
      x_end <= '0;
      y_end <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          x_q <= cmd_x;
          y_q <= cmd_y;
          w_q <= cmd_w;
          h_q <= cmd_h;
          color_q <= cmd_color;
          cmd_ready <= 1'b0;
          busy <= 1'b1;
          state <= SETUP;
        end
        SETUP: begin
          x_end <= x_end_c;
          y_end <= y_end_c;
          busy <= !empty;
          done <= empty;
          vram_we <= !empty;
          state <= empty ? DONE : FILL;
        end
        FILL: if (vram_ready && last) begin
          vram_we <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          cmd_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
